ahb_lite_decoder_mux: RTL and testbench

- Parametrised AHB-Lite interconnect slice: address decoder, slave response multiplexer and built-in default slave for NUM_SLAVES regions.
- Generalises the fixed two-slave, 1 KiB-region map to N slaves with per-slave start/end addresses.
- Adds a two-cycle ERROR response for unmapped accesses and a saturating decode-error counter.
- Sits between the single AHB-Lite master port and the slave ports in the example bench DUT.

---
 rtl/ahb_lite_decoder_mux.sv | 137 +++++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite interconnect slice: address decoder, slave response multiplexer and
// built-in default slave. The default slave answers unmapped transfers with a
// two-cycle ERROR and counts them.

package ahb_lite_decoder_mux_pkg;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Wide enough for 16 regions of up to 64 address bits.
  localparam int unsigned MAP_W = 1024;

  // Builds the default contiguous 1 KiB map: region i spans i*1024 + off.
  function automatic logic [MAP_W-1:0] region_map(int unsigned n, int unsigned aw,
                                                   int unsigned off);
    logic [MAP_W-1:0] map;
    logic [MAP_W-1:0] field;
    logic [MAP_W-1:0] mask;
    map  = '0;
    mask = (MAP_W'(1) << aw) - MAP_W'(1);
    for (int unsigned i = 0; i < n; i++) begin
      field = MAP_W'(i * 1024 + off) & mask;
      map   = map | (field << (i * aw));
    end
    return map;
  endfunction

endpackage

module ahb_lite_decoder_mux
  import ahb_lite_decoder_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES    = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] START_ADDR =
    (NUM_SLAVES*ADDR_WIDTH)'(region_map(NUM_SLAVES, ADDR_WIDTH, 0)),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] END_ADDR =
    (NUM_SLAVES*ADDR_WIDTH)'(region_map(NUM_SLAVES, ADDR_WIDTH, 1023)),
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [1:0]                       htrans,
  output logic [NUM_SLAVES-1:0]            hsel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]            s_hreadyout,
  input  logic [NUM_SLAVES-1:0]            s_hresp,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic                             hresp,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);

  // Data-phase select encoding: 0..NUM_SLAVES-1 are real slaves, DS is the
  // built-in default slave.
  localparam int unsigned        DSEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [DSEL_W-1:0]  DS     = DSEL_W'(NUM_SLAVES);

  logic                     hit;
  logic [DSEL_W-1:0]        hit_idx;
  logic                     err_req;
  logic [DSEL_W-1:0]        dsel_q, dsel_d;
  ds_state_e                state_q, state_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Address decode; scanning from the top down lets the lowest index win.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = DS;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (haddr >= START_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          haddr <= END_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = DSEL_W'(i);
      end
    end
    hsel = hit ? (NUM_SLAVES'(1) << hit_idx) : '0;
  end

  // Data-phase response mux; the default slave drives zero data.
  always_comb begin
    hrdata = '0;
    hready = (state_q != DS_ERR1);
    hresp  = (state_q != DS_IDLE);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        hrdata = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
        hready = s_hreadyout[i];
        hresp  = s_hresp[i];
      end
    end
  end

  // An unmapped active transfer is only taken when the bus accepts it.
  assign err_req = hready && !hit && (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ});

  // Next-state logic: default-slave FSM, data-phase select and error counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (err_req) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = err_req ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    dsel_d = hready ? hit_idx : dsel_q;
    cnt_d  = (err_req && (cnt_q != '1)) ? cnt_q + ERR_CNT_WIDTH'(1) : cnt_q;
  end

  // State registers; reset parks the data phase on an idle default slave.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DS_IDLE;
      dsel_q  <= DS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Self-checking bench: directed scenarios then random traffic, compared every
// cycle against a transaction-level model of the default 1 KiB region map.

module tb_ahb_lite_decoder_mux;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [127:0] s_hrdata;
  logic [3:0]   s_hreadyout;
  logic [3:0]   s_hresp;

  logic [3:0]   hsel,   hsel_s;
  logic [31:0]  hrdata, hrdata_s;
  logic         hready, hready_s;
  logic         hresp,  hresp_s;
  logic [15:0]  err_count;
  logic [1:0]   err_count_s;

  ahb_lite_decoder_mux dut (
    .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hsel(hsel),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .err_count(err_count)
  );

  ahb_lite_decoder_mux #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hsel(hsel_s),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .hrdata(hrdata_s), .hready(hready_s), .hresp(hresp_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: which slave owns the data phase (-1 = default slave), how many
  // error-response cycles remain, and how many errors were accepted.
  int m_sel      = -1;
  int m_err_left = 0;
  int m_cnt      = 0;
  bit exp_hready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    return (a < 32'd4096) ? int'(a / 32'd1024) : -1;
  endfunction

  function automatic bit active(input logic [1:0] t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

  task automatic model_reset();
    m_sel      = -1;
    m_err_left = 0;
    m_cnt      = 0;
  endtask

  task automatic check_outputs(input string tag);
    int          r;
    logic [3:0]  e_hsel;
    logic [31:0] e_rd;
    bit          e_resp;
    int          e_cnt, e_cnt_s;
    r      = region(haddr);
    e_hsel = (r >= 0) ? 4'(1 << r) : 4'b0;
    if (m_sel >= 0) begin
      e_rd       = s_hrdata[m_sel*32 +: 32];
      exp_hready = s_hreadyout[m_sel];
      e_resp     = s_hresp[m_sel];
    end else begin
      e_rd       = '0;
      exp_hready = (m_err_left != 2);
      e_resp     = (m_err_left != 0);
    end
    e_cnt   = (m_cnt > 65535) ? 65535 : m_cnt;
    e_cnt_s = (m_cnt > 3) ? 3 : m_cnt;
    check({tag, ".hsel"},      64'(hsel),        64'(e_hsel));
    check({tag, ".hrdata"},    64'(hrdata),      64'(e_rd));
    check({tag, ".hready"},    64'(hready),      64'(exp_hready));
    check({tag, ".hresp"},     64'(hresp),       64'(e_resp));
    check({tag, ".err_count"}, 64'(err_count),   64'(e_cnt));
    check({tag, ".sat_hsel"},  64'(hsel_s),      64'(e_hsel));
    check({tag, ".sat_rdata"}, 64'(hrdata_s),    64'(e_rd));
    check({tag, ".sat_ready"}, 64'(hready_s),    64'(exp_hready));
    check({tag, ".sat_resp"},  64'(hresp_s),     64'(e_resp));
    check({tag, ".sat_count"}, 64'(err_count_s), 64'(e_cnt_s));
  endtask

  // Advance the model across one clock edge using the values just checked.
  task automatic model_step();
    int r;
    if (rst) begin
      model_reset();
    end else if (exp_hready) begin
      r = region(haddr);
      if (r < 0 && active(htrans)) begin
        m_cnt++;
        m_err_left = 2;
      end else begin
        m_err_left = 0;
      end
      m_sel = r;
    end else if (m_sel < 0) begin
      m_err_left--;
    end
  endtask

  // One bus cycle: present the address phase, check mid-cycle, then clock.
  task automatic cycle(input logic [31:0] a, input logic [1:0] t, input string tag);
    haddr  = a;
    htrans = t;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    haddr       = 32'h0000_0404;
    htrans      = IDLE;
    s_hrdata    = {32'hDDDD_0003, 32'hCCCC_0002, 32'hA5A5_A5A5, 32'h1111_0000};
    s_hreadyout = 4'hF;
    s_hresp     = 4'h0;
    model_reset();

    // Reset values and combinational decode while in reset.
    #2;
    check("rst.hsel",      64'(hsel),      64'(4'b0010));
    check("rst.hready",    64'(hready),    64'(1'b1));
    check("rst.hresp",     64'(hresp),     64'(1'b0));
    check("rst.hrdata",    64'(hrdata),    64'(32'h0));
    check("rst.err_count", 64'(err_count), 64'(16'h0));
    cycle(32'h0000_0404, IDLE, "rst_hold");
    rst = 1'b0;

    // Mapped read from slave 1.
    cycle(32'h0000_0404, NONSEQ, "map1_addr");
    cycle(32'h0000_0000, IDLE,   "map1_data");

    // Single unmapped NONSEQ: ERR1, ERR2, count 1.
    cycle(32'h0000_2000, NONSEQ, "unmap_addr");
    cycle(32'h0000_0000, IDLE,   "unmap_err1");
    cycle(32'h0000_0000, IDLE,   "unmap_err2");
    cycle(32'h0000_0000, IDLE,   "unmap_idle");

    // Three back-to-back unmapped SEQ, each held through its ERR1 cycle.
    for (int k = 0; k < 3; k++) begin
      cycle(32'h0000_3000 + 32'(k * 4), SEQ, "b2b_seq_a");
      cycle(32'h0000_3000 + 32'(k * 4), SEQ, "b2b_seq_b");
    end
    cycle(32'h0000_0010, NONSEQ, "b2b_mapped");
    cycle(32'h0000_0000, IDLE,   "b2b_mapped_data");

    // Unmapped IDLE and BUSY are zero-wait OKAY and not counted.
    cycle(32'h0001_0000, IDLE, "unmap_idle_t");
    cycle(32'h0001_0000, BUSY, "unmap_busy_t");
    cycle(32'h0000_0000, IDLE, "unmap_idle_done");

    // Region boundaries.
    cycle(32'h0000_03FF, NONSEQ, "edge_3ff");
    cycle(32'h0000_0400, NONSEQ, "edge_400");
    cycle(32'h0000_0FFF, NONSEQ, "edge_fff");
    cycle(32'h0000_1000, NONSEQ, "edge_1000");
    cycle(32'h0000_0000, IDLE,   "edge_err1");
    cycle(32'h0000_0000, IDLE,   "edge_err2");

    // Slave 2 stalls while an unmapped NONSEQ waits in the address phase.
    cycle(32'h0000_0800, NONSEQ, "ws_addr");
    s_hreadyout[2] = 1'b0;
    for (int k = 0; k < 3; k++) cycle(32'h0000_6000, NONSEQ, "ws_stall");
    s_hreadyout[2] = 1'b1;
    cycle(32'h0000_6000, NONSEQ, "ws_release");
    cycle(32'h0000_0000, IDLE,   "ws_err1");
    cycle(32'h0000_0000, IDLE,   "ws_err2");

    // Asynchronous reset during ERR1.
    cycle(32'h0000_2000, NONSEQ, "arst_addr");
    haddr  = 32'h0000_0000;
    htrans = IDLE;
    @(negedge clk);
    check_outputs("arst_err1");
    #1 rst = 1'b1;
    #1;
    check("arst.hready",    64'(hready),      64'(1'b1));
    check("arst.hresp",     64'(hresp),       64'(1'b0));
    check("arst.err_count", 64'(err_count),   64'(16'h0));
    check("arst.sat_count", 64'(err_count_s), 64'(2'h0));
    @(posedge clk);
    model_step();
    #1;
    cycle(32'h0000_0000, IDLE, "arst_hold");
    rst = 1'b0;

    // Five unmapped NONSEQ transfers: the 2-bit counter saturates at 3.
    for (int k = 0; k < 10; k++) cycle(32'h0000_4000, NONSEQ, "sat");
    cycle(32'h0000_0000, IDLE, "sat_idle");
    cycle(32'h0000_0000, IDLE, "sat_idle2");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      int          pick;
      pick = int'($urandom_range(0, 4));
      if (pick == 4) a = $urandom | 32'h0000_1000;
      else           a = 32'(pick * 1024) + 32'($urandom_range(0, 1023));
      s_hrdata = {$urandom, $urandom, $urandom, $urandom};
      s_hresp  = 4'($urandom);
      for (int j = 0; j < 4; j++) s_hreadyout[j] = ($urandom_range(0, 3) != 0);
      cycle(a, 2'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
